// File: rtl/dm_sba_axi_master.sv
// dm_sba_axi_master: DM req/gnt to single-beat 64-bit AXI4 bridge, one outstanding; `SBA_RESP_ERR_EN reports SLVERR/DECERR on r_err_o
module dm_sba_axi_master #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [63:0]           r_rdata_o,
  output logic                  r_err_o,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [63:0]           w_data_o,
  output logic [7:0]            w_strb_o,
  output logic                  w_last_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  input  logic [1:0]            b_resp_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  input  logic [63:0]           r_data_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]            be_q, be_d;
  logic                  aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d;
  logic                  b_err, r_err;
  logic                  unused_sig;
`ifdef SBA_RESP_ERR_EN
  assign b_err = b_resp_i[1];
  assign r_err = r_resp_i[1];
`else
  assign b_err = 1'b0;
  assign r_err = 1'b0;
`endif
  assign unused_sig = ^{b_resp_i, r_resp_i, addr_i[2:0], 1'(AXI_ID)};
  assign gnt_o      = req_i & (state_q == IDLE);
  assign r_valid_o  = rvalid_q;
  assign r_rdata_o  = rdata_q;
  assign r_err_o    = err_q;
  assign aw_addr_o  = addr_q;
  assign ar_addr_o  = addr_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = be_q;
  assign w_last_o   = 1'b1;
  assign aw_valid_o = aw_pend_q;
  assign w_valid_o  = w_pend_q;
  assign ar_valid_o = state_q == RD_A;
  assign b_ready_o  = state_q == WR_B;
  assign r_ready_o  = state_q == RD_R;
  // next state, request capture and completion result
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: if (req_i) begin
        addr_d    = {addr_i[ADDR_WIDTH-1:3], 3'b0};
        wdata_d   = wdata_i;
        be_d      = be_i;
        aw_pend_d = we_i;
        w_pend_d  = we_i;
        state_d   = we_i ? WR : RD_A;
      end
      WR: begin
        aw_pend_d = aw_pend_q & ~aw_ready_i;
        w_pend_d  = w_pend_q & ~w_ready_i;
        state_d   = (aw_pend_d | w_pend_d) ? WR : WR_B;
      end
      WR_B: if (b_valid_i) begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = '0;
        err_d    = b_err;
      end
      RD_A: state_d = ar_ready_i ? RD_R : RD_A;
      RD_R: if (r_valid_i) begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = r_data_i;
        err_d    = r_err;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_dm_sba_axi_master.sv
// tb_dm_sba_axi_master: vector table, directed corner sequences and random transactions against a transaction-level model
module tb_dm_sba_axi_master;
  logic        clk_i = 1'b0, rst_i;
  logic        req_i, we_i, gnt_o, r_valid_o, r_err_o;
  logic [63:0] addr_i, wdata_i, r_rdata_o, aw_addr_o, w_data_o, ar_addr_o, r_data_i;
  logic [7:0]  be_i, w_strb_o;
  logic        aw_valid_o, aw_ready_i, w_last_o, w_valid_o, w_ready_i;
  logic [1:0]  b_resp_i, r_resp_i;
  logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] last_rdata = '0;

  dm_sba_axi_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .aw_addr_o(aw_addr_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_valid_o(w_valid_o),
    .w_ready_i(w_ready_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o), .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o),
    .ar_ready_i(ar_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [63:0] addr, wd;
    logic [7:0]  be;
    logic [63:0] rd;
    logic [1:0]  resp;
    logic [63:0] exp_addr, exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; r_valid_i = 0; b_resp_i = 0; r_resp_i = 0; r_data_i = '0;
  endtask

  function automatic bit exp_err(input logic [1:0] resp);
`ifdef SBA_RESP_ERR_EN
    return resp[1];
`else
    return 1'b0;
`endif
  endfunction

  // One transaction from grant to completion. The slave either answers with
  // fixed ready delays (cycles after grant) or randomly; response valid is
  // offered early so back-pressure is exercised.
  task automatic run_txn(input bit we, input logic [63:0] addr, wd, input logic [7:0] be,
                         input logic [63:0] rd, input logic [1:0] resp,
                         input logic [63:0] ea, erd, input bit rnd,
                         input int aw_d, w_d, ar_d, input bit hold, input bit chk_lat);
    bit g_aw = 0, g_w = 0, g_ar = 0, fin = 0, done = 0;
    req_i = 1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
    #1 chk("gnt", gnt_o, 1);
    for (int cyc = 1; cyc < 80 && !done; cyc++) begin
      tick;
      req_i = hold ? 1'b1 : (fin ? 1'b0 : 1'($urandom));
      we_i = 1'($urandom); addr_i = {$urandom, $urandom};
      wdata_i = {$urandom, $urandom}; be_i = 8'($urandom);
      aw_ready_i = rnd ? 1'($urandom) : (cyc > aw_d);
      w_ready_i  = rnd ? 1'($urandom) : (cyc > w_d);
      ar_ready_i = rnd ? 1'($urandom) : (cyc > ar_d);
      b_valid_i  = we & (rnd ? 1'($urandom) : 1'b1);
      r_valid_i  = !we & (rnd ? 1'($urandom) : 1'b1);
      b_resp_i = resp; r_resp_i = resp; r_data_i = rd;
      #1;
      chk("r_valid", r_valid_o, fin);
      if (fin) begin
        chk("r_rdata", r_rdata_o, erd);
        chk("r_err", r_err_o, exp_err(resp));
        if (chk_lat) chk("latency", cyc, 3);
        last_rdata = erd;
        done = 1;
      end else begin
        chk("gnt_busy", gnt_o, 0);
        chk("rdata_hold", r_rdata_o, last_rdata);
        chk("aw_valid", aw_valid_o, we & !g_aw);
        chk("w_valid", w_valid_o, we & !g_w);
        chk("ar_valid", ar_valid_o, !we & !g_ar);
        chk("b_ready", b_ready_o, we & g_aw & g_w);
        chk("r_ready", r_ready_o, !we & g_ar);
        chk("w_last", w_last_o, 1);
        if (aw_valid_o) chk("aw_addr", aw_addr_o, ea);
        if (w_valid_o) begin
          chk("w_data", w_data_o, wd);
          chk("w_strb", w_strb_o, be);
        end
        if (ar_valid_o) chk("ar_addr", ar_addr_o, ea);
        fin = we ? (g_aw & g_w & b_valid_i) : (g_ar & r_valid_i);
        g_aw |= we & aw_ready_i;
        g_w  |= we & w_ready_i;
        g_ar |= !we & ar_ready_i;
      end
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 64'h8000_0013, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[1] = '{1, 64'h1004, 64'h1122_3344_5566_7788, 8'hF0, 64'h0, 2'b00, 64'h1000, 64'h0};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1, 64'h7, 64'hA5A5_5A5A_0F0F_F0F0, 8'h01, 64'h0, 2'b11, 64'h0, 64'h0};
    vecs[4] = '{0, 64'h0, 64'h0, 8'h00, 64'h5555_AAAA_3333_CCCC, 2'b01, 64'h0, 64'h5555_AAAA_3333_CCCC};
    vecs[5] = '{1, 64'h1234_5678_9ABC_DEF9, 64'hFFFF_0000_FFFF_0000, 8'hFF, 64'h0, 2'b10, 64'h1234_5678_9ABC_DEF8, 64'h0};

    idle_inputs();
    rst_i = 1;
    repeat (3) tick;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_r_rdata", r_rdata_o, 0);
    chk("rst_r_err", r_err_o, 0);
    chk("rst_aw_valid", aw_valid_o, 0);
    chk("rst_w_valid", w_valid_o, 0);
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_w_last", w_last_o, 1);
    chk("rst_aw_addr", aw_addr_o, 0);
    chk("rst_w_data", w_data_o, 0);
    chk("rst_w_strb", w_strb_o, 0);
    rst_i = 0;
    tick;

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be, vecs[i].rd, vecs[i].resp,
              vecs[i].exp_addr, vecs[i].exp_rdata, 0, 0, 0, 0, 0, 1);

    // read with AR stalled for three cycles
    run_txn(0, 64'h8000_0013, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00,
            64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 3, 0, 0);
    // write with W accepted immediately and AW two cycles later
    run_txn(1, 64'h1004, 64'h1122_3344_5566_7788, 8'hF0, 64'h0, 2'b00,
            64'h1000, 64'h0, 0, 2, 0, 0, 0, 0);
    // two back-to-back reads with req_i held high
    run_txn(0, 64'h40, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 2'b00,
            64'h40, 64'h1111_2222_3333_4444, 0, 0, 0, 1, 1, 0);
    run_txn(0, 64'h4F, 64'h0, 8'h00, 64'h9999_8888_7777_6666, 2'b00,
            64'h48, 64'h9999_8888_7777_6666, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      bit          we;
      logic [63:0] a, rd;
      we = 1'($urandom);
      a  = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      run_txn(we, a, {$urandom, $urandom}, 8'($urandom), rd, 2'($urandom),
              {a[63:3], 3'b000}, we ? 64'h0 : rd, 1, 0, 0, 0, 1'($urandom), 0);
    end

    // reset after the AW handshake but before W
    run_txn(0, 64'h3000, 64'h0, 8'h00, 64'hFEED_FACE_0BAD_F00D, 2'b00,
            64'h3000, 64'hFEED_FACE_0BAD_F00D, 0, 0, 0, 0, 0, 1);
    req_i = 1; we_i = 1; addr_i = 64'h2000; wdata_i = 64'h77; be_i = 8'h0F;
    #1 chk("mid_gnt", gnt_o, 1);
    tick;
    req_i = 0; aw_ready_i = 1; w_ready_i = 0; b_valid_i = 1; r_valid_i = 0;
    #1 chk("mid_aw_valid", aw_valid_o, 1);
    chk("mid_w_valid", w_valid_o, 1);
    tick;
    aw_ready_i = 0; rst_i = 1;
    #1 chk("mid_aw_done", aw_valid_o, 0);
    chk("mid_w_pending", w_valid_o, 1);
    tick;
    rst_i = 0;
    chk("post_rst_w_valid", w_valid_o, 0);
    chk("post_rst_aw_valid", aw_valid_o, 0);
    chk("post_rst_b_ready", b_ready_o, 0);
    chk("post_rst_r_rdata", r_rdata_o, 0);
    last_rdata = '0;
    w_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abandoned_r_valid", r_valid_o, 0);
      chk("abandoned_w_valid", w_valid_o, 0);
      chk("abandoned_b_ready", b_ready_o, 0);
    end
    req_i = 1;
    #1 chk("post_rst_idle_gnt", gnt_o, 1);
    req_i = 0;
    idle_inputs();
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
